// File: rtl/chunked_add_subtractor.sv
// Multi-cycle adder/subtractor: walks the operands CHUNK bits per clock, LSB
// chunk first, through a registered carry/borrow chain with a start/busy/done handshake.
module chunked_add_subtractor #(
  parameter int WIDTH = 20,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int OW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // The chunk walk is tracked by bit offset rather than chunk index, so no multiply is needed.
  localparam logic [OW-1:0] LAST_OFF = OW'((N - 1) * CHUNK);
  localparam logic [OW-1:0] STEP     = OW'(CHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             mode_r;
  logic             chain_r;
  logic [OW-1:0]    off_r;

  logic [CHUNK:0]   op_s;
  logic             chain_next_s;
  logic [WIDTH-1:0] res_next_s;
  logic             ovf_s;

  // One chunk of a +/- b +/- chain; the extra top bit is carry-out (add) or borrow-out (sub).
  function automatic logic [CHUNK:0] chunk_op(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             add,
    input logic             cin
  );
    logic [CHUNK:0] ext_a;
    logic [CHUNK:0] ext_b;
    logic [CHUNK:0] ext_c;
    ext_a = {1'b0, a};
    ext_b = {1'b0, b};
    ext_c = {{CHUNK{1'b0}}, cin};
    if (add) begin
      return ext_a + ext_b + ext_c;
    end else begin
      return ext_a - ext_b - ext_c;
    end
  endfunction

  // Current chunk result, next chain bit and the partial result with this chunk merged in.
  always_comb begin
    op_s         = chunk_op(a_r[off_r +: CHUNK], b_r[off_r +: CHUNK], mode_r, chain_r);
    chain_next_s = op_s[CHUNK];
    res_next_s   = res_r;
    res_next_s[off_r +: CHUNK] = op_s[CHUNK-1:0];
    if (mode_r) begin
      ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_next_s[WIDTH-1] != a_r[WIDTH-1]);
    end else begin
      ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (res_next_s[WIDTH-1] != a_r[WIDTH-1]);
    end
  end

  // Control FSM, operand/chain datapath and registered result/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      mode_r  <= 1'b0;
      chain_r <= 1'b0;
      off_r   <= {OW{1'b0}};
      d       <= {WIDTH{1'b0}};
      bout    <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_r     <= i0;
            b_r     <= i1;
            mode_r  <= mode;
            chain_r <= 1'b0;
            off_r   <= {OW{1'b0}};
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          res_r   <= res_next_s;
          chain_r <= chain_next_s;
          off_r   <= off_r + STEP;
          if (off_r == LAST_OFF) begin
            d       <= res_next_s;
            bout    <= chain_next_s;
            zero    <= (res_next_s == {WIDTH{1'b0}});
            ovf     <= ovf_s;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_add_subtractor.sv
// Directed bench for chunked_add_subtractor: a 4-bit-chunk instance (N=5)
// and a single-chunk instance (N=1), with hand-computed expected results.
module tb_chunked_add_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode;
  logic [19:0] i0, i1;
  logic [19:0] d;
  logic        bout, zero, ovf, busy, done;

  logic        start1, mode1;
  logic [19:0] i0_1, i1_1;
  logic [19:0] d1;
  logic        bout1, zero1, ovf1, busy1, done1;

  int tests = 0;
  int fails = 0;
  int lat, bcnt, seen;

  always #5 clk = ~clk;

  chunked_add_subtractor #(.WIDTH(20), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .i0(i0), .i1(i1),
    .d(d), .bout(bout), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
  );

  chunked_add_subtractor #(.WIDTH(20), .CHUNK(20)) u1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .i0(i0_1), .i1(i1_1),
    .d(d1), .bout(bout1), .zero(zero1), .ovf(ovf1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and let the start edge sample it.
  task automatic launch(input logic m, input logic [19:0] a, input logic [19:0] b);
    start = 1'b1; mode = m; i0 = a; i1 = b;
    step();
    start = 1'b0;
  endtask

  // Edges counted from the start edge (inclusive) until done is seen; bounded.
  task automatic wait_done(output int l, output int bc);
    l = 1; bc = 0;
    while (done !== 1'b1 && l < 30) begin
      if (busy === 1'b1) bc++;
      step();
      l++;
    end
  endtask

  task automatic check_result(input string tag, input logic [19:0] ed, input logic eb,
                              input logic ez, input logic eo);
    check({tag, ".d"}, {12'd0, d}, {12'd0, ed});
    check({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; i0 = 20'd0; i1 = 20'd0;
    start1 = 1'b0; mode1 = 1'b0; i0_1 = 20'd0; i1_1 = 20'd0;
    step(); step();
    rst = 1'b0;
    check_result("reset", 20'h00000, 1'b0, 1'b0, 1'b0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);

    // 0 - 1: timing and wrap-around borrow
    launch(1'b0, 20'd0, 20'd1);
    wait_done(lat, bcnt);
    check("sub0m1.latency", lat, 32'd6);
    check("sub0m1.busy_cycles", bcnt, 32'd5);
    check_result("sub0m1", 20'hFFFFF, 1'b1, 1'b0, 1'b0);
    step();
    check("sub0m1.done_width", {31'd0, done}, 32'd0);

    launch(1'b0, 20'd110, 20'd110);
    wait_done(lat, bcnt);
    check_result("sub110", 20'd0, 1'b0, 1'b1, 1'b0);
    step();

    launch(1'b0, 20'd72, 20'd27);
    wait_done(lat, bcnt);
    check("sub72.latency", lat, 32'd6);
    check_result("sub72", 20'd45, 1'b0, 1'b0, 1'b0);
    step();

    launch(1'b1, 20'hFFFFF, 20'd1);
    wait_done(lat, bcnt);
    check_result("addwrap", 20'd0, 1'b1, 1'b1, 1'b0);
    step();

    launch(1'b0, 20'h80000, 20'd1);
    wait_done(lat, bcnt);
    check_result("subovf", 20'h7FFFF, 1'b0, 1'b0, 1'b1);
    step(); step(); step();
    check("hold.d", {12'd0, d}, {12'd0, 20'h7FFFF});
    check("hold.ovf", {31'd0, ovf}, 32'd1);

    // start held through RUN with new operands: must be ignored
    start = 1'b1; mode = 1'b0; i0 = 20'd72; i1 = 20'd27;
    step();
    mode = 1'b1; i0 = 20'd5; i1 = 20'd3;
    step(); step(); step(); step();
    start = 1'b0;
    step();
    check("hold_start.done", {31'd0, done}, 32'd1);
    check_result("hold_start", 20'd45, 1'b0, 1'b0, 1'b0);
    step();

    // back-to-back: start asserted in the DONE cycle
    launch(1'b1, 20'd100, 20'd23);
    wait_done(lat, bcnt);
    check_result("b2b_a", 20'd123, 1'b0, 1'b0, 1'b0);
    launch(1'b0, 20'd3, 20'd5);
    check("b2b.busy_after_done", {31'd0, busy}, 32'd1);
    check("b2b.d_holds", {12'd0, d}, {12'd0, 20'd123});
    wait_done(lat, bcnt);
    check("b2b.done_spacing", lat, 32'd6);
    check_result("b2b_b", 20'hFFFFE, 1'b1, 1'b0, 1'b0);
    step();

    // reset in the 3rd RUN cycle aborts with no done pulse
    launch(1'b0, 20'd9, 20'd4);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_result("abort", 20'd0, 1'b0, 1'b0, 1'b0);
    check("abort.busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    check("abort.no_activity", seen, 32'd0);
    launch(1'b0, 20'd72, 20'd27);
    wait_done(lat, bcnt);
    check("after_abort.latency", lat, 32'd6);
    check_result("after_abort", 20'd45, 1'b0, 1'b0, 1'b0);
    step();

    // single-chunk instance: N=1
    start1 = 1'b1; mode1 = 1'b0; i0_1 = 20'd0; i1_1 = 20'd1;
    step();
    start1 = 1'b0;
    check("n1.busy", {31'd0, busy1}, 32'd1);
    lat = 1;
    while (done1 !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    check("n1.latency", lat, 32'd2);
    check("n1.d", {12'd0, d1}, {12'd0, 20'hFFFFF});
    check("n1.bout", {31'd0, bout1}, 32'd1);
    check("n1.ovf", {31'd0, ovf1}, 32'd0);
    step();
    check("n1.done_width", {31'd0, done1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chunked_add_subtractor.md
Name: chunked_add_subtractor

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 20-bit combinational subtractor in the datapath.
- Processes operands CHUNK bits per clock, LSB chunk first, with a registered carry/borrow chain. This trades latency for a short critical path.
- Adds add/sub mode select, a start/busy/done handshake, and zero and signed-overflow flags.
- Sits between the register file read stage and ALU writeback.

Parameters:
- WIDTH, 20, operand/result width in bits.
- CHUNK, 4, bits processed per cycle. WIDTH must be an integer multiple of CHUNK; CHUNK = WIDTH is legal.
- N (local, derived), WIDTH/CHUNK, number of processing cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- mode  input  1  0 = subtract (i0 - i1), 1 = add (i0 + i1); latched with start
- i0  input  WIDTH  minuend/augend; latched with start
- i1  input  WIDTH  subtrahend/addend; latched with start
- d  output  WIDTH  result; registered
- bout  output  1  sub: borrow out of MSB (1 iff i0 < i1 unsigned); add: carry out
- zero  output  1  d == 0
- ovf  output  1  two's-complement signed overflow
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when d and flags update

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; d=0, bout=0, zero=0, ovf=0, busy=0, done=0; internal operand, partial-result, chunk-index and chain registers cleared.
- Reset has priority over everything, including mid-RUN. It aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch i0, i1, mode
  - chunk index = 0
  - chain bit = 0 (no borrow-in for sub, no carry-in for add)
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, edges E1..EN: at edge Ek, compute chunk k-1 = a_chunk ± b_chunk ± chain, store it into the partial result, update the chain bit, increment the index.
  - Sub: diff = a - b - borrow_in; borrow_out = 1 iff a < b + borrow_in.
  - Add: sum = a + b + carry_in; carry_out from the (CHUNK+1)-bit sum.
- At EN, in the same edge that processes the last chunk:
  - d ← full result
  - bout ← final chain bit
  - zero ← (result == 0)
  - ovf ← sub: sign(i0)≠sign(i1) and sign(d)≠sign(i0); add: sign(i0)=sign(i1) and sign(d)≠sign(i0)
  - state → DONE, done=1, busy=0.
- Latency: done is high in the cycle after EN, i.e. N+1 edges after start is sampled.
- busy=1 exactly while in RUN (N cycles).
- start during RUN is ignored. Operand and mode changes during RUN have no effect.
- DONE lasts one cycle, then returns to IDLE. If start=1 in DONE, a new operation is accepted in that edge: latch and go to RUN. This gives back-to-back operations with one idle-free gap.
- d, bout, zero, ovf hold their values between completions; they change only at the final RUN edge or at reset.
- CHUNK = WIDTH: N=1; RUN lasts one cycle.
- Arithmetic is modulo 2^WIDTH. Inputs are treated as unsigned for bout and as two's complement for ovf.

Test Plan (WIDTH=20, CHUNK=4, N=5):
- rst=1 for 2 cycles, then start with i0=0, i1=1, sub -> busy high 5 cycles; done pulse 6 edges after start; d=0xFFFFF, bout=1, zero=0, ovf=0.
- Sub i0=110, i1=110 -> d=0, bout=0, zero=1, ovf=0. Then sub i0=72, i1=27 -> d=45, flags 0.
- Add i0=0xFFFFF, i1=1 -> d=0, bout=1, zero=1, ovf=0. Sub i0=0x80000, i1=1 -> d=0x7FFFF, bout=0, ovf=1.
- start held during RUN with different operands -> ignored, result of first op only. Start asserted in DONE cycle -> second op accepted immediately, done pulses exactly 6 cycles apart.
- rst pulsed at 3rd RUN cycle -> no done; all outputs 0 next cycle; subsequent op 72-27 completes normally with d=45.
- Re-run with CHUNK=20 (N=1): sub 0-1 -> done 2 edges after start, d=0xFFFFF, bout=1.
